// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Shared types and helpers for the BIST sequencer:
//   - bist_state_e   : sequencer states
//   - DEF_*          : default polynomials and seed for the 18-in/19-out CUT
//   - lfsr_next()    : one Fibonacci shift-left step with XOR feedback
//   - misr_next()    : one LFSR step with parallel data folded in
// The helpers work on a MAX_W-wide container plus an explicit width so one
// function body serves every register width; callers zero-extend their
// operands and keep the low bits of the result.
// ---------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } bist_state_e;

    localparam int MAX_W = 64;

    localparam logic [17:0] DEF_LFSR_POLY = 18'h20400;
    localparam logic [17:0] DEF_LFSR_SEED = 18'h00001;
    localparam logic [18:0] DEF_MISR_POLY = 19'h40023;

    function automatic logic [MAX_W-1:0] width_mask(input int width);
        logic [MAX_W-1:0] m;
        if (width >= MAX_W) m = '1;
        else                m = (64'd1 << width) - 64'd1;
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] lfsr_next(
        input logic [MAX_W-1:0] value,
        input logic [MAX_W-1:0] poly,
        input int               width
    );
        logic [MAX_W-1:0] v;
        v = value & width_mask(width);
        return {v[MAX_W-2:0], ^(v & poly)} & width_mask(width);
    endfunction

    function automatic logic [MAX_W-1:0] misr_next(
        input logic [MAX_W-1:0] value,
        input logic [MAX_W-1:0] poly,
        input logic [MAX_W-1:0] data,
        input int               width
    );
        return lfsr_next(value, poly, width) ^ (data & width_mask(width));
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// ---------------------------------------------------------------------------
// bist_lfsr
// Generic shift register used both as the pattern LFSR and as the MISR.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads INIT_VAL)
//   load       : synchronous reload to INIT_VAL (highest priority)
//   shr        : logical shift right by one, zero fill at the MSB
//   en         : advance one LFSR/MISR step
//   compress   : 1 = fold din into the step (MISR), 0 = plain LFSR
//   din        : parallel data compressed when compress=1
//   q          : register contents
//   nxt        : value q would take on an enabled step
// ---------------------------------------------------------------------------
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int           W        = 18,
    parameter logic [W-1:0] POLY     = '0,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shr,
    input  logic         en,
    input  logic         compress,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt
);

    logic [MAX_W-1:0] step_ext;
    logic             unused_hi;

    always_comb begin
        step_ext = '0;
        if (compress)
            step_ext = misr_next({{(MAX_W-W){1'b0}}, q}, {{(MAX_W-W){1'b0}}, POLY},
                                 {{(MAX_W-W){1'b0}}, din}, W);
        else
            step_ext = lfsr_next({{(MAX_W-W){1'b0}}, q}, {{(MAX_W-W){1'b0}}, POLY}, W);
    end

    assign nxt       = step_ext[W-1:0];
    assign unused_hi = ^step_ext[MAX_W-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= INIT_VAL;
        else if (load) q <= INIT_VAL;
        else if (shr)  q <= {1'b0, q[W-1:1]};
        else if (en)   q <= nxt;
    end

endmodule

// File: rtl/bist_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bist_seq_ctrl
// BIST sequencer for one CUT: clears the CUT through its synchronous-clear
// input, applies NUM_PAT LFSR patterns, compacts the responses in a MISR and
// compares the final signature with GOLDEN_SIG.
// Ports:
//   CK, RN     : clock, asynchronous active-low reset
//   start      : launch request (honoured in IDLE and DONE)
//   cut_in     : vector driven into the CUT
//   cut_out    : CUT response, compacted while in RUN
//   busy       : INIT or RUN
//   done       : DONE state
//   pass       : final signature matched GOLDEN_SIG (valid with done)
//   signature  : MISR contents
//   sig_shift  : (BIST_SIG_SHIFT_EN) shift MISR right while in DONE
//   sig_sout   : (BIST_SIG_SHIFT_EN) serial signature, LSB first
// Build option: define BIST_SIG_SHIFT_EN to add the serial signature
// readout; without it the MISR is frozen in DONE.
// ---------------------------------------------------------------------------
module bist_seq_ctrl
    import bist_pkg::*;
#(
    parameter int                 NUM_IN      = 18,
    parameter int                 NUM_OUT     = 19,
    parameter logic [NUM_IN-1:0]  LFSR_POLY   = DEF_LFSR_POLY,
    parameter logic [NUM_IN-1:0]  LFSR_SEED   = DEF_LFSR_SEED,
    parameter logic [NUM_OUT-1:0] MISR_POLY   = DEF_MISR_POLY,
    parameter int                 RST_BIT     = 17,
    parameter int                 INIT_CYCLES = 2,
    parameter int                 NUM_PAT     = 1000,
    parameter logic [NUM_OUT-1:0] GOLDEN_SIG  = '0
) (
    input  logic               CK,
    input  logic               RN,
    input  logic               start,
`ifdef BIST_SIG_SHIFT_EN
    input  logic               sig_shift,
    output logic               sig_sout,
`endif
    output logic [NUM_IN-1:0]  cut_in,
    input  logic [NUM_OUT-1:0] cut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_OUT-1:0] signature
);

    localparam int ICW = $clog2(INIT_CYCLES + 1);
    localparam int PCW = $clog2(NUM_PAT + 1);

    bist_state_e        state, state_nxt;
    logic [ICW-1:0]     init_cnt;
    logic [PCW-1:0]     pat_cnt;
    logic               reload, step_en, last_pat, misr_shr;
    logic [NUM_IN-1:0]  lfsr_q, lfsr_nxt_unused;
    logic [NUM_OUT-1:0] misr_q, misr_nxt;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        reload    = 1'b0;
        step_en   = 1'b0;
        last_pat  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cut_in    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = INIT;
                    reload    = 1'b1;
                end
            end
            INIT: begin
                busy            = 1'b1;
                cut_in[RST_BIT] = 1'b1;
                if (init_cnt == ICW'(INIT_CYCLES - 1)) state_nxt = RUN;
            end
            RUN: begin
                busy            = 1'b1;
                step_en         = 1'b1;
                cut_in          = lfsr_q;
                // The clear input must stay low while patterns are applied.
                cut_in[RST_BIT] = 1'b0;
                if (pat_cnt == PCW'(NUM_PAT - 1)) begin
                    last_pat  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = INIT;
                    reload    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            init_cnt <= '0;
            pat_cnt  <= '0;
            pass     <= 1'b0;
        end else if (reload) begin
            init_cnt <= '0;
            pat_cnt  <= '0;
            pass     <= 1'b0;
        end else begin
            if (state == INIT) init_cnt <= init_cnt + ICW'(1);
            if (state == RUN)  pat_cnt  <= pat_cnt + PCW'(1);
            // Compare against the value being captured on this edge.
            if (last_pat)      pass     <= (misr_nxt == GOLDEN_SIG);
        end
    end

`ifdef BIST_SIG_SHIFT_EN
    assign misr_shr = (state == DONE) && sig_shift;
    assign sig_sout = misr_q[0];
`else
    assign misr_shr = 1'b0;
`endif

    bist_lfsr #(
        .W        (NUM_IN),
        .POLY     (LFSR_POLY),
        .INIT_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk      (CK),
        .rst_n    (RN),
        .load     (reload),
        .shr      (1'b0),
        .en       (step_en),
        .compress (1'b0),
        .din      ('0),
        .q        (lfsr_q),
        .nxt      (lfsr_nxt_unused)
    );

    bist_lfsr #(
        .W        (NUM_OUT),
        .POLY     (MISR_POLY),
        .INIT_VAL ('0)
    ) u_misr (
        .clk      (CK),
        .rst_n    (RN),
        .load     (reload),
        .shr      (misr_shr),
        .en       (step_en),
        .compress (1'b1),
        .din      (cut_out),
        .q        (misr_q),
        .nxt      (misr_nxt)
    );

    assign signature = misr_q;

endmodule
